// File: rtl/btn_event_arbiter_pkg.sv
// btn_pkg: shared FSM states, button codes, default settle time and the round-robin pick
package btn_pkg;
  typedef enum logic {IDLE, SETTLE} state_t;
  typedef enum logic [1:0] {BTN_N, BTN_E, BTN_S, BTN_W} btn_code_t;
  localparam int DEF_SETTLE_CYCLES = 500000;
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    rr_pick = last;
    for (int k = 4; k >= 1; k--)
      if (req[2'(last + 2'(k))]) rr_pick = 2'(last + 2'(k));
  endfunction
endpackage

// File: rtl/btn_event_arbiter_if.sv
// btn_event_arbiter_if: raw buttons in, debounced events and levels out
interface btn_event_arbiter_if;
  logic btn_north;
  logic btn_east;
  logic btn_south;
  logic btn_west;
  logic evt_valid;
  logic [1:0] evt_code;
  logic evt_press;
  logic [3:0] btn_state;
  logic busy;
  modport master(input btn_north, btn_east, btn_south, btn_west,
                 output evt_valid, evt_code, evt_press, btn_state, busy);
  modport slave(output btn_north, btn_east, btn_south, btn_west,
                input evt_valid, evt_code, evt_press, btn_state, busy);
endinterface

// File: rtl/btn_event_arbiter_sync.sv
// btn_sync: 2-flop synchronizer for one asynchronous button
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  // shift the raw level through two flops
  always_ff @(posedge clk)
    if (rst) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: round-robin shared settle counter for four buttons; BTN_RELEASE_EVT_EN adds release events
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W = 19
) (
  input logic clk,
  input logic rst,
  btn_event_arbiter_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  logic [3:0] raw, sync, req;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, last_q, last_d, evt_code_q, evt_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] btn_state_q, btn_state_d;
  logic evt_valid_q, evt_valid_d, evt_press_q, evt_press_d;
  assign raw = {bus.btn_west, bus.btn_south, bus.btn_east, bus.btn_north};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_sync
    btn_sync u_sync (.clk(clk), .rst(rst), .d(raw[i]), .q(sync[i]));
  end
  assign req = sync ^ btn_state_q;
  // grant in IDLE (one cooldown cycle after an event keeps events SETTLE_CYCLES+2 apart), settle the granted button
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    btn_state_d = btn_state_q;
    evt_valid_d = 1'b0;
    evt_code_d = evt_code_q;
    evt_press_d = evt_press_q;
    if (state_q == IDLE) begin
      if (req != 4'b0 && !evt_valid_q) begin
        grant_d = rr_pick(req, last_q);
        cnt_d = '0;
        state_d = SETTLE;
      end
    end else if (!req[grant_q]) begin
      last_d = grant_q;
      state_d = IDLE;
    end else if (cnt_q == CNT_LAST) begin
      btn_state_d[grant_q] = sync[grant_q];
      last_d = grant_q;
      state_d = IDLE;
      evt_code_d = grant_q;
      evt_press_d = sync[grant_q];
`ifdef BTN_RELEASE_EVT_EN
      evt_valid_d = 1'b1;
`else
      evt_valid_d = sync[grant_q];
`endif
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q <= BTN_W;
      cnt_q <= '0;
      btn_state_q <= 4'b0;
      evt_valid_q <= 1'b0;
      evt_code_q <= 2'd0;
      evt_press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      btn_state_q <= btn_state_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q <= evt_code_d;
      evt_press_q <= evt_press_d;
    end
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code = evt_code_q;
  assign bus.evt_press = evt_press_q;
  assign bus.btn_state = btn_state_q;
  assign bus.busy = (state_q == SETTLE);
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed scenarios plus randomized run checked against debounce rules
module tb_btn_event_arbiter;
  localparam int SC = 4;
`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] raw = 4'b0;
  int checks = 0;
  int failures = 0;
  int pc = 0;
  int last_rst = -100;
  logic [3:0] hist[$];
  int ev_cyc[$];
  logic [1:0] ev_code[$];
  logic ev_pr[$];
  int busy_cnt;
  always #5 clk = ~clk;
  btn_event_arbiter_if bus();
  assign bus.btn_north = raw[0];
  assign bus.btn_east = raw[1];
  assign bus.btn_south = raw[2];
  assign bus.btn_west = raw[3];
  btn_event_arbiter #(.SETTLE_CYCLES(SC), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) begin
    hist.push_back(raw);
    if (rst) last_rst = pc;
    pc++;
  end
  task step();
    @(negedge clk);
  endtask
  task do_reset();
    rst = 1'b1;
    raw = 4'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  task watch(input int n);
    ev_cyc.delete();
    ev_code.delete();
    ev_pr.delete();
    busy_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (bus.evt_valid) begin
        ev_cyc.push_back(k);
        ev_code.push_back(bus.evt_code);
        ev_pr.push_back(bus.evt_press);
      end
      if (bus.busy) busy_cnt++;
    end
  endtask
  task test_reset();
    rst = 1'b1;
    raw = 4'b1111;
    step();
    step();
    checks++;
    if ({bus.evt_valid, bus.evt_code, bus.evt_press, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outs: got %b expected 00000", {bus.evt_valid, bus.evt_code, bus.evt_press, bus.busy});
    end
    checks++;
    if (bus.btn_state !== 4'b0) begin
      failures++;
      $display("FAIL reset_state: got %b expected 0000", bus.btn_state);
    end
    raw = 4'b0;
    rst = 1'b0;
  endtask
  task test_press_north();
    do_reset();
    raw = 4'b0001;
    watch(14);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++;
      $display("FAIL north_count: got %0d expected 1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_cyc[0] !== 7) begin failures++; $display("FAIL north_latency: got %0d expected 7", ev_cyc[0]); end
      checks++;
      if ({ev_code[0], ev_pr[0]} !== 3'b001) begin failures++; $display("FAIL north_evt: got %b expected 001", {ev_code[0], ev_pr[0]}); end
    end
    checks++;
    if (busy_cnt !== SC) begin failures++; $display("FAIL north_busy: got %0d expected %0d", busy_cnt, SC); end
    checks++;
    if (bus.btn_state !== 4'b0001) begin failures++; $display("FAIL north_state: got %b expected 0001", bus.btn_state); end
  endtask
  task test_bounce();
    do_reset();
    raw = 4'b0010;
    step();
    step();
    raw = 4'b0;
    watch(15);
    checks++;
    if (ev_cyc.size() !== 0) begin failures++; $display("FAIL bounce_count: got %0d expected 0", ev_cyc.size()); end
    checks++;
    if ({bus.btn_state, bus.busy} !== 5'b0) begin failures++; $display("FAIL bounce_idle: got %b expected 00000", {bus.btn_state, bus.busy}); end
  endtask
  task test_simultaneous();
    do_reset();
    raw = 4'b0101;
    watch(24);
    checks++;
    if (ev_cyc.size() !== 2) begin
      failures++;
      $display("FAIL simul_count: got %0d expected 2", ev_cyc.size());
    end else begin
      checks++;
      if ({ev_code[0], ev_code[1]} !== 4'b0010) begin failures++; $display("FAIL simul_order: got %b expected 0010", {ev_code[0], ev_code[1]}); end
      checks++;
      if (ev_cyc[1] - ev_cyc[0] < SC + 2) begin failures++; $display("FAIL simul_gap: got %0d expected >=%0d", ev_cyc[1] - ev_cyc[0], SC + 2); end
    end
    checks++;
    if (bus.btn_state !== 4'b0101) begin failures++; $display("FAIL simul_state: got %b expected 0101", bus.btn_state); end
  endtask
  task test_swap();
    do_reset();
    raw = 4'b0001;
    watch(10);
    raw = 4'b0010;
    watch(24);
    checks++;
    if (ev_cyc.size() !== (REL ? 2 : 1)) begin
      failures++;
      $display("FAIL swap_count: got %0d expected %0d", ev_cyc.size(), REL ? 2 : 1);
    end else begin
      checks++;
      if ({ev_code[0], ev_pr[0]} !== 3'b011) begin failures++; $display("FAIL swap_first: got %b expected 011", {ev_code[0], ev_pr[0]}); end
      if (REL) begin
        checks++;
        if ({ev_code[1], ev_pr[1]} !== 3'b000) begin failures++; $display("FAIL swap_second: got %b expected 000", {ev_code[1], ev_pr[1]}); end
      end
    end
    checks++;
    if (bus.btn_state !== 4'b0010) begin failures++; $display("FAIL swap_state: got %b expected 0010", bus.btn_state); end
  endtask
  task test_release_west();
    do_reset();
    raw = 4'b1000;
    watch(10);
    checks++;
    if (ev_cyc.size() !== 1 || {ev_code[0], ev_pr[0]} !== 3'b111) begin
      failures++;
      $display("FAIL west_press: got %0d events expected 1 with code 3 press 1", ev_cyc.size());
    end
    raw = 4'b0;
    watch(12);
    checks++;
    if (ev_cyc.size() !== (REL ? 1 : 0) || (REL && {ev_code[0], ev_pr[0]} !== 3'b110)) begin
      failures++;
      $display("FAIL west_release: got %0d events expected %0d", ev_cyc.size(), REL ? 1 : 0);
    end
    checks++;
    if (bus.btn_state !== 4'b0) begin failures++; $display("FAIL west_state: got %b expected 0000", bus.btn_state); end
  endtask
  task test_rst_mid();
    do_reset();
    raw = 4'b0001;
    watch(4);
    checks++;
    if (ev_cyc.size() !== 0 || !bus.busy) begin failures++; $display("FAIL rstmid_pre: got events=%0d busy=%b expected 0 and 1", ev_cyc.size(), bus.busy); end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.evt_valid, bus.busy, bus.btn_state} !== 6'b0) begin failures++; $display("FAIL rstmid_abort: got %b expected 000000", {bus.evt_valid, bus.busy, bus.btn_state}); end
    rst = 1'b0;
    watch(12);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++;
      $display("FAIL rstmid_count: got %0d expected 1", ev_cyc.size());
    end else begin
      checks++;
      if (ev_cyc[0] !== 7 || ev_code[0] !== 2'd0) begin failures++; $display("FAIL rstmid_evt: got cycle %0d code %0d expected 7 and 0", ev_cyc[0], ev_code[0]); end
    end
  endtask
  task test_random();
    int last_ev, p, n;
    logic [3:0] prev_state, chg;
    logic [1:0] g;
    logic pr;
    bit stable;
    do_reset();
    last_ev = -100;
    prev_state = 4'b0;
    for (int seg = 0; seg <= 60; seg++) begin
      if (seg < 60) raw = 4'($urandom);
      n = (seg < 60) ? $urandom_range(1, 12) : 80;
      for (int k = 0; k < n; k++) begin
        step();
        p = pc - 1;
        chg = bus.btn_state ^ prev_state;
        if (bus.evt_valid) begin
          g = bus.evt_code;
          pr = bus.evt_press;
          checks++;
          if (p - last_ev < SC + 2) begin failures++; $display("FAIL rand_gap: got %0d expected >=%0d", p - last_ev, SC + 2); end
          checks++;
          if (pr !== ~prev_state[g] || chg !== 4'(1 << g) || bus.btn_state[g] !== pr) begin
            failures++;
            $display("FAIL rand_flip: got state %b press %b code %0d from %b", bus.btn_state, pr, g, prev_state);
          end
          if (!REL) begin
            checks++;
            if (pr !== 1'b1) begin failures++; $display("FAIL rand_press_only: got %b expected 1", pr); end
          end
          if (p - 6 > last_rst) begin
            stable = 1'b1;
            for (int j = p - 6; j <= p - 2; j++) if (hist[j][g] !== pr) stable = 1'b0;
            checks++;
            if (!stable) begin failures++; $display("FAIL rand_stable: got unstable input for code %0d expected %0d-cycle hold", g, SC + 1); end
          end
          last_ev = p;
        end else begin
          checks++;
          if (REL ? (chg !== 4'b0) : ((chg & bus.btn_state) !== 4'b0)) begin
            failures++;
            $display("FAIL rand_silent: got state %b from %b with no event", bus.btn_state, prev_state);
          end
        end
        prev_state = bus.btn_state;
      end
    end
    checks++;
    if (bus.btn_state !== raw) begin failures++; $display("FAIL rand_final: got %b expected %b", bus.btn_state, raw); end
  endtask
  initial begin
    test_reset();
    test_press_north();
    test_bounce();
    test_simultaneous();
    test_swap();
    test_release_west();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
